// File: rtl/sig_pwl_pipe.sv
// Pipelined piecewise-linear sigmoid/tanh with a runtime-loadable positive-half segment table.
// Define SIG_PWL_ROUND_EN to round (half-up) the interpolation shift instead of truncating it.
module sig_pwl_pipe #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 8,
    parameter int SEG_BITS = 3,
    parameter int SLOPE_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sat,
    input  logic                cfg_we,
    input  logic [SEG_BITS-1:0] cfg_addr,
    input  logic [OUT_W-1:0]    cfg_base,
    input  logic [SLOPE_W-1:0]  cfg_slope
);
    localparam int OFF_W  = IN_W - 1 - SEG_BITS;
    localparam int NSEG   = 1 << SEG_BITS;
    localparam int PROD_W = SLOPE_W + OFF_W;
    localparam int F_W    = ((OUT_W > SLOPE_W) ? OUT_W : SLOPE_W) + 1;
    localparam logic [F_W-1:0] ONE_F  = F_W'(1) << (OUT_W - 1);
    localparam logic [F_W-1:0] ONE_M1 = ONE_F - F_W'(1);
`ifdef SIG_PWL_ROUND_EN
    localparam logic [PROD_W:0] HALF = (PROD_W + 1)'(1) << (OFF_W - 1);
`endif

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic [OUT_W-1:0]   base_q  [NSEG];
    logic [SLOPE_W-1:0] slope_q [NSEG];

    // Written at the edge, so a sample captured on the same edge still sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSEG; i++) begin
                base_q[i]  <= '0;
                slope_q[i] <= '0;
            end
        end else if (cfg_we) begin
            base_q[cfg_addr]  <= cfg_base;
            slope_q[cfg_addr] <= cfg_slope;
        end
    end

    logic                neg_d, sat_d;
    logic [IN_W-2:0]     mag_d;
    logic [SEG_BITS-1:0] seg_d;

    always_comb begin
        neg_d = in_data[IN_W-1];
        sat_d = neg_d && (in_data[IN_W-2:0] == '0);
        if (sat_d)
            mag_d = '1;
        else if (neg_d)
            mag_d = ~in_data[IN_W-2:0] + (IN_W - 1)'(1);
        else
            mag_d = in_data[IN_W-2:0];
        seg_d = mag_d[IN_W-2 -: SEG_BITS];
    end

    logic               v1_q, neg1_q, mode1_q, sat1_q;
    logic [OFF_W-1:0]   off1_q;
    logic [OUT_W-1:0]   base1_q;
    logic [SLOPE_W-1:0] slope1_q;
    logic               v2_q, neg2_q, mode2_q, sat2_q;
    logic [OUT_W-1:0]   base2_q;
    logic [PROD_W-1:0]  prod2_q;
    logic               v3_q, neg3_q, mode3_q, sat3_q;
    logic [F_W-1:0]     f3_q;
    logic               out_valid_q, out_sat_q;
    logic [OUT_W-1:0]   out_data_q;

    // Interpolation is split: multiply registered in S2, shift+add into S3.
    logic [PROD_W:0] prod_r, shr;
    logic [F_W-1:0]  f_d;

    always_comb begin
`ifdef SIG_PWL_ROUND_EN
        prod_r = {1'b0, prod2_q} + HALF;
`else
        prod_r = {1'b0, prod2_q};
`endif
        shr = prod_r >> OFF_W;
        f_d = F_W'(base2_q) + F_W'(shr);
    end

    logic [F_W-1:0]   lim, fc;
    logic             clamp_d;
    logic [OUT_W-1:0] res_d;

    always_comb begin
        lim     = mode3_q ? ONE_M1 : ONE_F;
        clamp_d = f3_q > lim;
        fc      = clamp_d ? lim : f3_q;
        if (!neg3_q)
            res_d = OUT_W'(fc);
        else if (mode3_q)
            res_d = OUT_W'(-fc);
        else
            res_d = OUT_W'(ONE_F - fc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; neg1_q <= 1'b0; mode1_q <= 1'b0; sat1_q <= 1'b0;
            off1_q <= '0; base1_q <= '0; slope1_q <= '0;
            v2_q <= 1'b0; neg2_q <= 1'b0; mode2_q <= 1'b0; sat2_q <= 1'b0;
            base2_q <= '0; prod2_q <= '0;
            v3_q <= 1'b0; neg3_q <= 1'b0; mode3_q <= 1'b0; sat3_q <= 1'b0;
            f3_q <= '0;
            out_valid_q <= 1'b0; out_data_q <= '0; out_sat_q <= 1'b0;
        end else if (adv) begin
            v1_q     <= in_valid;
            neg1_q   <= neg_d;
            mode1_q  <= in_mode;
            sat1_q   <= sat_d;
            off1_q   <= mag_d[OFF_W-1:0];
            base1_q  <= base_q[seg_d];
            slope1_q <= slope_q[seg_d];

            v2_q    <= v1_q;
            neg2_q  <= neg1_q;
            mode2_q <= mode1_q;
            sat2_q  <= sat1_q;
            base2_q <= base1_q;
            prod2_q <= PROD_W'(slope1_q) * PROD_W'(off1_q);

            v3_q    <= v2_q;
            neg3_q  <= neg2_q;
            mode3_q <= mode2_q;
            sat3_q  <= sat2_q;
            f3_q    <= f_d;

            out_valid_q <= v3_q;
            out_data_q  <= res_d;
            out_sat_q   <= clamp_d | sat3_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
endmodule
